// File: rtl/ex_div_if.sv
// Request/response bundle between the EX stage and the multi-cycle divider.
// The EX stage drives the master side; the divider is the slave.
interface ex_div_if;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   modport master (
      output signed_div_i,
      output opdata1_i,
      output opdata2_i,
      output start_i,
      output annul_i,
      input  result_o,
      input  ready_o
   );

   modport slave (
      input  signed_div_i,
      input  opdata1_i,
      input  opdata2_i,
      input  start_i,
      input  annul_i,
      output result_o,
      output ready_o
   );
endinterface : ex_div_if

// File: rtl/ex_div.sv
// 32-bit restoring divider for the EX stage: one quotient bit per cycle,
// signed or unsigned, result = {remainder, quotient}, cancellable by annul_i.
module ex_div (
   input  logic     clk,
   input  logic     rst,
   ex_div_if.slave  div_bus
);

   typedef enum logic [1:0] {
      DivFree   = 2'd0,
      DivByZero = 2'd1,
      DivOn     = 2'd2,
      DivEnd    = 2'd3
   } div_state_e;

   localparam logic [5:0] LAST_STEP = 6'd32;

   div_state_e  r_state;
   logic [5:0]  r_cnt;
   logic [64:0] r_work;
   logic [31:0] r_divisor;
   logic        r_quot_neg;
   logic        r_rem_neg;
   logic [63:0] r_result;
   logic        r_ready;

   div_state_e  w_state_nxt;
   logic [5:0]  w_cnt_nxt;
   logic [64:0] w_work_nxt;
   logic [31:0] w_divisor_nxt;
   logic        w_quot_neg_nxt;
   logic        w_rem_neg_nxt;
   logic [63:0] w_result_nxt;
   logic        w_ready_nxt;

   logic        w_accept;
   logic [31:0] w_dividend_abs;
   logic [31:0] w_divisor_abs;
   logic [32:0] w_diff;
   logic [31:0] w_quot;
   logic [31:0] w_rem;

   // Magnitudes are only taken for negative operands of a signed divide.
   assign w_dividend_abs = (div_bus.signed_div_i && div_bus.opdata1_i[31])
                         ? (~div_bus.opdata1_i + 32'd1) : div_bus.opdata1_i;
   assign w_divisor_abs  = (div_bus.signed_div_i && div_bus.opdata2_i[31])
                         ? (~div_bus.opdata2_i + 32'd1) : div_bus.opdata2_i;

   assign w_accept = div_bus.start_i && !div_bus.annul_i;

   // The 33rd bit is the borrow: set means the trial subtraction went negative.
   assign w_diff = {1'b0, r_work[63:32]} - {1'b0, r_divisor};

   assign w_quot = r_quot_neg ? (~r_work[31:0]  + 32'd1) : r_work[31:0];
   assign w_rem  = r_rem_neg  ? (~r_work[64:33] + 32'd1) : r_work[64:33];

   always_comb begin
      // NOTE: every output of this block gets a default first so that no path
      // through the case leaves a signal unassigned, which would infer a latch.
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_work_nxt     = r_work;
      w_divisor_nxt  = r_divisor;
      w_quot_neg_nxt = r_quot_neg;
      w_rem_neg_nxt  = r_rem_neg;
      w_result_nxt   = r_result;
      w_ready_nxt    = r_ready;

      unique case (r_state)
         DivFree: begin
            w_ready_nxt  = 1'b0;
            w_result_nxt = 64'h0;
            if (w_accept) begin
               if (div_bus.opdata2_i == 32'h0) begin
                  w_state_nxt = DivByZero;
               end else begin
                  w_state_nxt    = DivOn;
                  w_cnt_nxt      = 6'd0;
                  w_work_nxt     = {32'h0, w_dividend_abs, 1'b0};
                  w_divisor_nxt  = w_divisor_abs;
                  w_quot_neg_nxt = div_bus.signed_div_i
                                 & (div_bus.opdata1_i[31] ^ div_bus.opdata2_i[31]);
                  w_rem_neg_nxt  = div_bus.signed_div_i & div_bus.opdata1_i[31];
               end
            end
         end

         DivByZero: begin
            w_result_nxt = 64'h0;
            if (div_bus.annul_i) begin
               w_state_nxt = DivFree;
               w_ready_nxt = 1'b0;
               w_cnt_nxt   = 6'd0;
            end else begin
               w_state_nxt = DivEnd;
               w_ready_nxt = 1'b1;
            end
         end

         DivOn: begin
            if (div_bus.annul_i) begin
               w_state_nxt  = DivFree;
               w_ready_nxt  = 1'b0;
               w_result_nxt = 64'h0;
               w_cnt_nxt    = 6'd0;
            end else if (r_cnt != LAST_STEP) begin
               if (w_diff[32]) begin
                  w_work_nxt = {r_work[63:0], 1'b0};
               end else begin
                  w_work_nxt = {w_diff[31:0], r_work[31:0], 1'b1};
               end
               w_cnt_nxt = r_cnt + 6'd1;
            end else begin
               w_result_nxt = {w_rem, w_quot};
               w_ready_nxt  = 1'b1;
               w_state_nxt  = DivEnd;
            end
         end

         DivEnd: begin
            // annul_i is ignored here: the EX stage drops the result via its own flush.
            if (!div_bus.start_i) begin
               w_state_nxt  = DivFree;
               w_ready_nxt  = 1'b0;
               w_result_nxt = 64'h0;
            end
         end

         default: begin
            w_state_nxt  = DivFree;
            w_ready_nxt  = 1'b0;
            w_result_nxt = 64'h0;
            w_cnt_nxt    = 6'd0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= DivFree;
         r_cnt      <= 6'd0;
         r_work     <= 65'h0;
         r_divisor  <= 32'h0;
         r_quot_neg <= 1'b0;
         r_rem_neg  <= 1'b0;
         r_result   <= 64'h0;
         r_ready    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_work     <= w_work_nxt;
         r_divisor  <= w_divisor_nxt;
         r_quot_neg <= w_quot_neg_nxt;
         r_rem_neg  <= w_rem_neg_nxt;
         r_result   <= w_result_nxt;
         r_ready    <= w_ready_nxt;
      end
   end

   assign div_bus.result_o = r_result;
   assign div_bus.ready_o  = r_ready;

endmodule : ex_div

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: drivers push expected {result, ready cycle},
// a negedge monitor pops and compares whenever ready_o rises.
module tb_ex_div;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ex_div_if bus ();

   ex_div dut (
      .clk     (clk),
      .rst     (rst),
      .div_bus (bus)
   );

   typedef struct {
      logic [63:0] result;
      int unsigned ready_cyc;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;
   logic        prev_ready = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: magnitude divide with C-style truncation signs; zero divisor gives 0.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
      longint sa, sb, ma, mb, q, r;
      if (b == 32'h0) return 64'h0;
      sa = sgn ? longint'($signed(a)) : longint'({32'h0, a});
      sb = sgn ? longint'($signed(b)) : longint'({32'h0, b});
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      q  = ma / mb;
      r  = ma % mb;
      if ((sa < 0) != (sb < 0)) q = -q;
      if (sa < 0) r = -r;
      return {r[31:0], q[31:0]};
   endfunction

   // Monitor: compares every rising ready_o against the scoreboard head.
   always @(negedge clk) begin
      if (rst) begin
         prev_ready = 1'b0;
      end else begin
         if (bus.ready_o && !prev_ready) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_ready: got result %h at cycle %0d, expected no result",
                        bus.result_o, cyc);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("mon_result", bus.result_o, e.result);
               check("mon_latency", 64'(cyc), 64'(e.ready_cyc));
            end
         end
         prev_ready = bus.ready_o;
      end
   end

   task automatic wait_ready(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL %s_timeout: ready_o still 0 after 40 cycles, expected 1", name);
         sb_q.delete();
      end
   endtask

   // Hold start_i for `hold` cycles after ready, then release and check the clear.
   task automatic finish_div(input string name, input logic [63:0] exp, input int hold,
                             input bit annul_end);
      for (int h = 0; h < hold; h++) begin
         bus.annul_i = annul_end && (h == 0);
         @(negedge clk);
         bus.annul_i = 1'b0;
         check({name, "_hold_ready"}, 64'(bus.ready_o), 64'd1);
         check({name, "_hold_result"}, bus.result_o, exp);
      end
      bus.start_i = 1'b0;
      @(negedge clk);
      check({name, "_rel_ready"}, 64'(bus.ready_o), 64'd0);
      check({name, "_rel_result"}, bus.result_o, 64'h0);
   endtask

   task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp, input int hold,
                         input bit annul_end);
      bit          ok;
      int unsigned lat;
      @(negedge clk);
      bus.signed_div_i = sgn;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
      bus.annul_i      = 1'b0;
      lat = (b == 32'h0) ? 1 : 33;
      sb_q.push_back('{result: exp, ready_cyc: cyc + 1 + lat});
      // Operands are scrambled after acceptance; only the latched values may matter.
      @(negedge clk);
      bus.opdata1_i    = $urandom;
      bus.opdata2_i    = $urandom;
      bus.signed_div_i = 1'($urandom_range(0, 1));
      if (bus.ready_o) ok = 1'b1;
      else wait_ready(name, ok);
      if (ok) finish_div(name, exp, hold, annul_end);
      else bus.start_i = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      bit          ok;
      bit          seen_ready;
      logic [31:0] a, b;
      logic        sgn;
      int unsigned sel;

      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'h0;
      bus.opdata2_i    = 32'h0;
      bus.start_i      = 1'b0;
      bus.annul_i      = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_ready", 64'(bus.ready_o), 64'd0);
      check("reset_result", bus.result_o, 64'h0);
      rst = 1'b0;

      do_div("u100_7",     32'd100,      32'd7,        1'b0, 64'h00000002_0000000E, 2, 1'b1);
      do_div("s_m7_2",     32'hFFFFFFF9, 32'h00000002, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 1, 1'b0);
      do_div("s_7_m2",     32'h00000007, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 0, 1'b0);
      do_div("u_div0",     32'h12345678, 32'h0,        1'b0, 64'h0,                 1, 1'b0);
      do_div("s_div0",     32'h80000001, 32'h0,        1'b1, 64'h0,                 0, 1'b0);
      do_div("u_max_1",    32'hFFFFFFFF, 32'h1,        1'b0, 64'h00000000_FFFFFFFF, 0, 1'b0);
      do_div("s_min_m1",   32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 0, 1'b0);

      // Annul at E10 of 50/3: no result may ever appear.
      @(negedge clk);
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd50;
      bus.opdata2_i    = 32'd3;
      bus.start_i      = 1'b1;
      repeat (10) @(negedge clk);
      bus.annul_i = 1'b1;
      bus.start_i = 1'b0;
      @(negedge clk);
      bus.annul_i = 1'b0;
      check("annul_ready", 64'(bus.ready_o), 64'd0);
      check("annul_result", bus.result_o, 64'h0);
      seen_ready = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.ready_o) seen_ready = 1'b1;
      end
      check("annul_no_ready", 64'(seen_ready), 64'd0);
      do_div("u9_3_after_annul", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 0, 1'b0);

      // Reset at E20 of 1000/9 with start held; start must be re-accepted right after.
      @(negedge clk);
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = 32'd1000;
      bus.opdata2_i    = 32'd9;
      bus.start_i      = 1'b1;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_ready", 64'(bus.ready_o), 64'd0);
      check("midrst_result", bus.result_o, 64'h0);
      rst = 1'b0;
      sb_q.push_back('{result: 64'h00000001_0000006F, ready_cyc: cyc + 1 + 33});
      wait_ready("after_rst", ok);
      if (ok) finish_div("after_rst", 64'h00000001_0000006F, 1, 1'b0);
      else bus.start_i = 1'b0;

      // Randomized divides against the arithmetic model.
      for (int n = 0; n < 24; n++) begin
         sel = $urandom_range(0, 7);
         a   = ($urandom_range(0, 5) == 0) ? 32'h80000000 : 32'($urandom);
         case (sel)
            0:       b = 32'h0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = 32'hFFFFFFFF;
            default: b = 32'($urandom);
         endcase
         sgn = 1'($urandom_range(0, 1));
         do_div($sformatf("rand%0d", n), a, b, sgn, ref_div(a, b, sgn),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      repeat (2) @(negedge clk);
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_ex_div

// File: doc/ex_div.md
EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- signed_div_i  in  1  1 = signed divide (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  EX stage requests a divide; held high until ready_o is seen
- annul_i  in  1  cancel the in-flight divide (flush/exception)
- result_o  out  64  {remainder[63:32], quotient[31:0]}, feeding EX hi/lo and then EX/MEM
- ready_o  out  1  result_o valid; EX stage releases its stall request on this
REQ-003 All outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have four states: DivFree, DivByZero, DivOn and DivEnd.
REQ-005 DivFree behaviour:
- start_i=1, annul_i=0, opdata2_i==0: go to DivByZero.
- start_i=1, annul_i=0, opdata2_i!=0: go to DivOn with cnt=0.
- Otherwise stay in DivFree, with ready_o=0 and result_o=0.
REQ-006 On entry to DivOn, the block SHALL latch operands:
- signed_div_i=1: take absolute values (two's complement) of negative operands.
- Record quotient-negative = opdata1_i[31] XOR opdata2_i[31].
- Record remainder-negative = opdata1_i[31].
- Load the 65-bit work register with {32'b0, |dividend|, 1'b0}.
REQ-007 Each DivOn cycle with cnt<32 and annul_i=0 SHALL perform one restoring step:
- diff = work[63:32] - |divisor|, 33-bit.
- diff negative: work <= {work[63:0], 1'b0}.
- Otherwise: work <= {diff[31:0], work[31:0], 1'b1}.
- Then cnt <= cnt+1.
REQ-008 In DivOn with cnt==32, the block SHALL:
- Set quotient = work[31:0] and remainder = work[64:33].
- Negate each if its recorded sign flag is set; sign flags apply only when signed.
- Drive result_o={remainder, quotient} and ready_o=1.
- Go to DivEnd.
REQ-009 DivByZero SHALL go to DivEnd on the next edge with result_o=64'h0 and ready_o=1.
REQ-010 In DivEnd, ready_o and result_o SHALL hold while start_i=1. When start_i=0, the block SHALL go to DivFree with ready_o=0 and result_o=0 on that edge.
REQ-011 Latency, counting from edge E0 that accepts start:
- Non-zero divisor: ready_o=1 after edge E33.
- Zero divisor: ready_o=1 after edge E1.
REQ-012 annul_i=1 in DivOn or DivByZero SHALL return the FSM to DivFree on that edge, with ready_o=0, result_o=0 and cnt=0. No result SHALL be produced.
REQ-013 annul_i=1 in DivEnd SHALL NOT clear the result; EX ignores it via its own flush.
REQ-014 In DivFree, annul_i=1 together with start_i=1 SHALL leave the FSM in DivFree.
REQ-015 Operand changes while not in DivFree SHALL have no effect; only the values latched at E0 are used.
REQ-016 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (natural wrap, no trap).
REQ-017 A new divide SHALL start only after start_i has been seen low in DivEnd. Back-to-back divides therefore need one DivFree cycle.

Reset
REQ-018 rst=1 at any edge, including mid-divide, SHALL force:
- state = DivFree
- cnt = 0
- work = 0
- sign flags = 0
- result_o = 64'h0
- ready_o = 0
REQ-019 After rst falls, a start_i already high SHALL be accepted on the first edge with rst=0.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Unsigned 100/7, start held → ready_o rises after E33; result_o=64'h00000002_0000000E; ready_o held until start_i drops, then 0 next edge.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero, any dividend → ready_o after E1; result_o=64'h0.
- Unsigned 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remainder 0; signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0.
- annul_i pulsed at E10 during 50/3 → state DivFree at E10, ready_o never rises; a new start (9/3) then gives 64'h00000000_00000003 after its own E33.
- rst asserted at E20 mid-divide → all outputs 0 next edge; a divide restarted after reset completes with the correct result and full latency.
